// File: rtl/xmas_scene_sequencer.sv
// Frame-rate scene controller for the Christmas-tree VGA scene: turns vsync into
// a frame tick and sequences tree -> typed text -> hold -> blink, plus star/garland animation.
module xmas_scene_sequencer #(
  parameter int TREE_FRAMES      = 60,
  parameter int FRAMES_PER_CHAR  = 8,
  parameter int TEXT1_LEN        = 10,
  parameter int TEXT2_LEN        = 18,
  parameter int HOLD_FRAMES      = 120,
  parameter int BLINK_FRAMES     = 64,
  parameter int STAR_PERIOD      = 32,
  parameter int VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       vsync_i,
  input  logic       pause_i,
  input  logic       skip_i,
  output logic [2:0] state_o,
  output logic [4:0] text1_count_o,
  output logic [4:0] text2_count_o,
  output logic       text_show_o,
  output logic [1:0] star_color_o,
  output logic [2:0] light_phase_o,
  output logic       frame_tick_o
);

  typedef enum logic [2:0] {
    S_TREE = 3'd0, S_TYPE1 = 3'd1, S_TYPE2 = 3'd2, S_HOLD = 3'd3, S_BLINK = 3'd4
  } state_e;

  localparam logic [7:0] TREE_LAST  = 8'(TREE_FRAMES - 1);
  localparam logic [7:0] CHAR_LAST  = 8'(FRAMES_PER_CHAR - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] STAR_LAST  = 8'(STAR_PERIOD - 1);
  localparam logic [4:0] LEN1       = 5'(TEXT1_LEN);
  localparam logic [4:0] LEN2       = 5'(TEXT2_LEN);
  localparam logic       VS_INV     = (VSYNC_ACTIVE_LOW != 0);

  state_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [4:0] t1_q, t1_d, t2_q, t2_d;
  logic       show_q, show_d;
  logic [7:0] star_cnt_q;
  logic [1:0] star_color_q;
  logic [2:0] light_q;
  logic       vact_q, frame_tick_q;
  logic       v_act, tick, adv;

  // vact_q resets to the active level so a vsync already active at release is not a frame edge
  assign v_act = vsync_i ^ VS_INV;
  assign tick  = v_act & ~vact_q;
  assign adv   = tick & ~pause_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_TREE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (skip_i) state_d = S_HOLD;
    else begin
      case (state_q)
        S_TREE:  if (adv && frame_cnt_q == TREE_LAST) state_d = S_TYPE1;
        S_TYPE1: if (adv && frame_cnt_q == CHAR_LAST && t1_q == LEN1 - 5'd1) state_d = S_TYPE2;
        S_TYPE2: if (adv && frame_cnt_q == CHAR_LAST && t2_q == LEN2 - 5'd1) state_d = S_HOLD;
        S_HOLD:  if (adv && frame_cnt_q == HOLD_LAST) state_d = S_BLINK;
        S_BLINK: if (adv && frame_cnt_q == BLINK_LAST) state_d = S_TREE;
        default: state_d = S_TREE;
      endcase
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    show_d      = show_q;
    if (skip_i) begin
      frame_cnt_d = '0;
      t1_d        = LEN1;
      t2_d        = LEN2;
      show_d      = 1'b1;
    end else begin
      case (state_q)
        S_TREE:  if (adv) frame_cnt_d = (frame_cnt_q == TREE_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
        S_TYPE1: if (adv) begin
          if (frame_cnt_q == CHAR_LAST) begin
            frame_cnt_d = '0;
            if (t1_q < LEN1) t1_d = t1_q + 5'd1;
          end else frame_cnt_d = frame_cnt_q + 8'd1;
        end
        S_TYPE2: if (adv) begin
          if (frame_cnt_q == CHAR_LAST) begin
            frame_cnt_d = '0;
            if (t2_q < LEN2) t2_d = t2_q + 5'd1;
          end else frame_cnt_d = frame_cnt_q + 8'd1;
        end
        S_HOLD:  if (adv) frame_cnt_d = (frame_cnt_q == HOLD_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
        S_BLINK: if (adv) begin
          // leaving BLINK wins over a toggle landing on the same frame
          if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d = '0;
            t1_d        = '0;
            t2_d        = '0;
            show_d      = 1'b1;
          end else begin
            if (frame_cnt_q[2:0] == 3'd7) show_d = ~show_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: begin
          frame_cnt_d = '0;
          t1_d        = '0;
          t2_d        = '0;
          show_d      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      frame_cnt_q  <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      show_q       <= 1'b1;
      star_cnt_q   <= '0;
      star_color_q <= '0;
      light_q      <= '0;
      vact_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      show_q       <= show_d;
      vact_q       <= v_act;
      frame_tick_q <= tick;
      if (adv) begin
        light_q <= light_q + 3'd1;
        if (star_cnt_q == STAR_LAST) begin
          star_cnt_q   <= '0;
          star_color_q <= star_color_q + 2'd1;
        end else star_cnt_q <= star_cnt_q + 8'd1;
      end
    end
  end

  assign state_o       = state_q;
  assign text1_count_o = t1_q;
  assign text2_count_o = t2_q;
  assign text_show_o   = show_q;
  assign star_color_o  = star_color_q;
  assign light_phase_o = light_q;
  assign frame_tick_o  = frame_tick_q;

endmodule

// File: tb/tb_xmas_scene_sequencer.sv
// Directed bench for xmas_scene_sequencer with short scene timings and hand-computed expectations.
module tb_xmas_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, vsync, pause, skip;
  logic [2:0] state, light_phase;
  logic [4:0] text1_count, text2_count;
  logic       text_show, frame_tick;
  logic [1:0] star_color;

  int nvec = 0;
  int nerr = 0;
  int ft_cnt = 0;
  int ft_base;

  always #5 clk = ~clk;

  xmas_scene_sequencer #(
    .TREE_FRAMES(3), .FRAMES_PER_CHAR(2), .TEXT1_LEN(10), .TEXT2_LEN(18),
    .HOLD_FRAMES(4), .BLINK_FRAMES(16), .STAR_PERIOD(4), .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .vsync_i(vsync), .pause_i(pause), .skip_i(skip),
    .state_o(state), .text1_count_o(text1_count), .text2_count_o(text2_count),
    .text_show_o(text_show), .star_color_o(star_color), .light_phase_o(light_phase),
    .frame_tick_o(frame_tick)
  );

  always @(negedge clk) if (frame_tick) ft_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // vsync high for 3 cycles then a 2-cycle low pulse; ends two negedges after the falling edge
  task automatic frame();
    @(negedge clk) vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, state, 0);
    chk({tag, ".t1"}, text1_count, 0);
    chk({tag, ".t2"}, text2_count, 0);
    chk({tag, ".show"}, text_show, 1);
    chk({tag, ".star"}, star_color, 0);
    chk({tag, ".light"}, light_phase, 0);
    chk({tag, ".tick"}, frame_tick, 0);
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; pause = 1'b0; skip = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("no_tick_at_release", ft_cnt, 0);

    for (int t = 1; t <= 79; t++) begin
      frame();
      case (t)
        1: begin
          chk("t1.ticks", ft_cnt, 1);
          chk("t1.tick_low", frame_tick, 0);
          chk("t1.light", light_phase, 1);
        end
        2:  chk("t2.state", state, 0);
        3:  chk("t3.state", state, 1);
        4:  chk("t4.star", star_color, 1);
        5:  chk("t5.t1", text1_count, 1);
        8:  chk("t8.light", light_phase, 0);
        16: chk("t16.star", star_color, 0);
        22: begin chk("t22.t1", text1_count, 9); chk("t22.state", state, 1); end
        23: begin chk("t23.t1", text1_count, 10); chk("t23.state", state, 2); end
        58: begin chk("t58.t2", text2_count, 17); chk("t58.state", state, 2); end
        59: begin chk("t59.t2", text2_count, 18); chk("t59.state", state, 3); end
        62: chk("t62.state", state, 3);
        63: chk("t63.state", state, 4);
        70: chk("t70.show", text_show, 1);
        71: chk("t71.show", text_show, 0);
        78: begin chk("t78.state", state, 4); chk("t78.show", text_show, 0); end
        79: begin
          chk("t79.state", state, 0);
          chk("t79.t1", text1_count, 0);
          chk("t79.t2", text2_count, 0);
          chk("t79.show", text_show, 1);
        end
        default: ;
      endcase
    end
    chk("ticks79", ft_cnt, 79);

    // ticks 80..82 leave TREE, tick 84 reveals first character
    repeat (5) frame();
    chk("t84.state", state, 1);
    chk("t84.t1", text1_count, 1);
    chk("t84.light", light_phase, 4);
    chk("t84.star", star_color, 1);

    pause = 1'b1;
    ft_base = ft_cnt;
    repeat (5) frame();
    chk("pause.state", state, 1);
    chk("pause.t1", text1_count, 1);
    chk("pause.star", star_color, 1);
    chk("pause.light", light_phase, 4);
    chk("pause.ticks", ft_cnt - ft_base, 5);
    pause = 1'b0;

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    // skip lands on the same edge as the first tick while in TREE
    @(negedge clk) vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0; skip = 1'b1;
    @(negedge clk) skip = 1'b0;
    chk("skip.tick", frame_tick, 1);
    @(negedge clk);
    chk("skip.state", state, 3);
    chk("skip.t1", text1_count, 10);
    chk("skip.t2", text2_count, 18);
    chk("skip.show", text_show, 1);
    chk("skip.light", light_phase, 1);
    chk("skip.star", star_color, 0);

    repeat (3) frame();
    chk("hold3.state", state, 3);
    frame();
    chk("blink.state", state, 4);
    chk("blink.t1", text1_count, 10);
    repeat (8) frame();
    chk("blink8.show", text_show, 0);
    chk("blink8.light", light_phase, 5);
    chk("blink8.star", star_color, 3);

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/xmas_scene_sequencer.md
Name: xmas_scene_sequencer

Overview:
Frame-rate animation controller for the VGA Christmas-tree scene. Detects frame boundaries from the sync generator's vsync and steps through a fixed scene sequence: tree only, type line 1, type line 2, hold, blink, repeat. Drives the per-line visible-character counts, the text show/blank gate, the star colour select and the light-chase phase. Output is consumed combinationally by the pixel/colour datapath.

Parameters:
TREE_FRAMES, 60, frames spent in TREE state (1..255)
FRAMES_PER_CHAR, 8, frames between successive revealed characters (1..255)
TEXT1_LEN, 10, character slots on line 1
TEXT2_LEN, 18, character slots on line 2
HOLD_FRAMES, 120, frames in HOLD (1..255)
BLINK_FRAMES, 64, frames in BLINK (1..255)
STAR_PERIOD, 32, frames per star colour step (1..255)
VSYNC_ACTIVE_LOW, 1, vsync polarity (1 = active-low)

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, synchronous, active-low
vsync  in  1  vertical sync from hvsync generator
pause  in  1  level; freezes animation while high
skip  in  1  one-cycle pulse; jump to fully revealed HOLD
state  out  3  0=TREE 1=TYPE1 2=TYPE2 3=HOLD 4=BLINK
text1_count  out  5  visible characters on line 1 (0..TEXT1_LEN)
text2_count  out  5  visible characters on line 2 (0..TEXT2_LEN)
text_show  out  1  text gate; 0 blanks all text
star_color  out  2  star colour select
light_phase  out  3  garland chase offset
frame_tick  out  1  one-cycle pulse per frame

Behaviour:
- One clock; reset synchronous active-low: sampled on the clk edge only. All outputs and state registers are registered.
- Reset values: state=TREE, text1_count=0, text2_count=0, text_show=1, star_color=0, light_phase=0, frame_tick=0, internal frame_cnt=0, star_cnt=0. vsync_q resets to the ACTIVE level, so vsync already active at reset release produces no tick.
- Tick: v_act = vsync XOR VSYNC_ACTIVE_LOW. tick_int = v_act & ~vsync_q_act. frame_tick = tick_int registered, so it is high exactly one cycle per frame. All animation registers update on the same edge that sets frame_tick.
- pause=1: tick_int is ignored by FSM, star_cnt and light_phase (all frozen). frame_tick still pulses. skip is still honoured.
- light_phase: +1 per unpaused tick; wraps 7->0.
- Star: star_cnt +1 per unpaused tick. At star_cnt==STAR_PERIOD-1: star_cnt<=0 and star_color+1 (wraps 3->0). Independent of FSM and skip.
- FSM, on unpaused tick (frame_cnt is 8-bit and clears on every state change):
  - TREE: frame_cnt==TREE_FRAMES-1 -> TYPE1; else frame_cnt+1.
  - TYPE1: frame_cnt==FRAMES_PER_CHAR-1 -> frame_cnt<=0, text1_count+1. If text1_count was TEXT1_LEN-1 -> TYPE2.
  - TYPE2: same rule on text2_count/TEXT2_LEN -> HOLD.
  - HOLD: frame_cnt==HOLD_FRAMES-1 -> BLINK.
  - BLINK: text_show toggles whenever frame_cnt[2:0]==7 before increment (every 8 ticks). At frame_cnt==BLINK_FRAMES-1 -> TREE with text1_count=0, text2_count=0, text_show=1. The exit takes priority over a coincident toggle.
- Without a tick, nothing changes except vsync_q.
- skip (any state, any pause): next edge sets state=HOLD, text1_count=TEXT1_LEN, text2_count=TEXT2_LEN, text_show=1, frame_cnt=0. A coincident FSM tick is dropped. Star and light_phase still advance on that tick.
- Counts never exceed their LEN. States 5..7 are unreachable. If reached, they recover to TREE on the next edge.
- Reset asserted mid-sequence returns all outputs to reset values on that edge.

Test Plan:
Params TREE=3, FPC=2, HOLD=4, BLINK=16, STAR=4, active-low vsync, 2-cycle low pulse per frame.
- Reset release with vsync low -> no frame_tick. The first falling vsync edge gives frame_tick high for exactly 1 cycle, and light_phase=1.
- Ticks 1-3 -> state 0 then 1 after tick 3. Ticks 5,7,...,23 -> text1_count increments to 10. state=2 after tick 23.
- Continue to tick 59 -> text2_count=18, state=3. Tick 63 -> state=4. text_show=0 after tick 71. Tick 79 -> state=0, counts 0, text_show=1.
- Star check: after 4 ticks star_color=1. After 16 ticks star_color=0 (wrap). light_phase=0 after 8 ticks.
- pause held across 5 ticks in TYPE1 -> state, counts, star_color and light_phase unchanged. frame_tick still pulses 5 times.
- skip pulse coincident with a tick in TREE -> state=3, text1_count=10, text2_count=18. Reset asserted in BLINK -> all outputs at reset values on the next edge.
